mdu_hilo: RTL
=============

# mdu_hilo

Multi-cycle multiply/divide unit with the architectural HI/LO registers, sitting in the E stage of the five-stage MIPS pipeline. It is the responding end of the `start`/`busy` stall protocol consumed by the hazard unit: the E stage pulses `start` for a mult/div, and the unit holds `busy` for the operation latency. While `start || busy` is high, any D-stage instruction that uses HI/LO is frozen. It also services MTHI/MTLO writes and MFHI/MFLO reads.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU
- DIV_CYCLES, 10, busy duration for DIV/DIVU

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low; the block is reset when `reset` is 0 at a clk edge
- start  in  1  one-cycle pulse from the E stage; valid only with a mult/div `op`
- op  in  4  E-stage MDU operation: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO
- a  in  32  forwarded rs value (E stage)
- b  in  32  forwarded rt value (E stage)
- busy  out  1  operation in flight; registered
- hilo_out  out  32  HI if `op`=MFHI, LO if `op`=MFLO, else 0; combinational from the registers
- hi  out  32  current HI register (debug/verification)
- lo  out  32  current LO register (debug/verification)

## Operation
- State: IDLE and RUN. A down-counter of 4 bits (enough for 10) plus pending registers `p_hi` and `p_lo`.
- IDLE, `start`=1, op in {MULT, MULTU, DIV, DIVU}:
  - compute the full result from `a`/`b` in this cycle and latch it into `p_hi`/`p_lo`
  - load the counter with MULT_CYCLES or DIV_CYCLES
  - go to RUN
- RUN:
  - decrement the counter each cycle
  - when the counter reaches 1: copy `p_hi`/`p_lo` into HI/LO and return to IDLE
- MULT / MULTU: signed / unsigned 32x32→64. HI = upper word, LO = lower word.
- DIV / DIVU: signed / unsigned. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
- Divide by zero: the full latency still runs; HI/LO are left unchanged at completion.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- MTHI / MTLO: write `a` to HI / LO at the clock edge when in IDLE and `start`=0. If busy, the write is dropped.
- `start` while in RUN: ignored. The in-flight operation completes unchanged; the hazard unit must never produce this.
- `start` with a non-mult/div `op`: ignored.
- `hilo_out` returns the committed HI/LO only, never the pending values.

## Timing
- Reset (`reset`=0 at an edge): HI=0, LO=0, `p_hi`=0, `p_lo`=0, counter=0, state IDLE, `busy`=0, so `hilo_out`=0.
- Reset mid-operation: the operation is discarded and its result is never committed.
- Operation latency, with `start` sampled at edge T:
  - `busy`=1 for cycles T+1 .. T+N, where N = MULT_CYCLES or DIV_CYCLES
  - HI/LO are updated at the edge ending cycle T+N
  - `busy`=0 and the new HI/LO are visible from cycle T+N+1
- Back-to-back operations: the earliest next `start` is in cycle T+N+1. No bubble is required beyond the deassertion of `busy`.
- MFHI/MFLO in cycle T+N+1 reads the new value. This is guaranteed by the hazard unit stalling while `start || busy`.
- MTHI/MTLO: the new value is visible on `hilo_out` in the next cycle.

## Structure
- The op encoding (4-bit constants MDU_NONE..MDU_MTLO) goes in the shared pipeline constants header. Control decode and this block both include it.
- MULT_CYCLES and DIV_CYCLES defaults also live there.
- No sub-module. The arithmetic is inline Verilog `*`, `/`, `%` on sign-extended or zero-extended 33/64-bit operands.
- The single always block holds state, counter and the HI/LO registers; `hilo_out` is a continuous assign.

## Test plan
- Reset, then MTHI `a`=0x12345678 followed by MFHI:
  - `hilo_out`=0x12345678 one cycle later
  - asserting `reset`=0 for one cycle clears HI, LO and `busy` to 0
- MULT `a`=0xFFFFFFFE, `b`=3:
  - `busy` high exactly 5 cycles
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA
- Same operands with MULTU:
  - HI=0x00000002, LO=0xFFFFFFFA
- DIV `a`=-7 (0xFFFFFFF9), `b`=2:
  - `busy` high exactly 10 cycles
  - LO=0xFFFFFFFD, HI=0xFFFFFFFF
  - HI/LO unchanged before cycle T+11
- DIVU with `b`=0 after preloading HI=0xA, LO=0xB:
  - `busy` high 10 cycles
  - HI=0xA, LO=0xB afterwards
- DIV 0x80000000 / 0xFFFFFFFF:
  - LO=0x80000000, HI=0
- MULT issued, then at T+2 a second `start`, then MTLO at T+3, then `reset`=0 at T+4:
  - second `start` and MTLO ignored
  - after reset HI=LO=0 and `busy`=0

Source files
------------

// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: shared MDU op encoding, default latencies and FSM state type
package mdu_hilo_pkg;
    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    typedef enum logic {S_IDLE, S_RUN} state_t;
    function automatic logic is_md(input logic [3:0] o);
        return o == MDU_MULT || o == MDU_MULTU || o == MDU_DIV || o == MDU_DIVU;
    endfunction
endpackage

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO registers
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hilo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t state;
    logic [3:0] cnt;
    logic [31:0] p_hi, p_lo;
    logic p_wr;
    logic sgn, is_mul;
    logic [63:0] ma, mb, prod;
    logic signed [32:0] da, db;
    logic [31:0] quot, rem;
    assign sgn    = op == MDU_MULT || op == MDU_DIV;
    assign is_mul = op == MDU_MULT || op == MDU_MULTU;
    assign ma     = {{32{sgn & a[31]}}, a};
    assign mb     = {{32{sgn & b[31]}}, b};
    assign prod   = ma * mb;
    assign da     = {sgn & a[31], a};
    // zero divisor is replaced by 1 to keep the datapath defined; its result is never committed
    assign db     = b == 32'd0 ? 33'sd1 : {sgn & b[31], b};
    assign quot   = 32'(da / db);
    assign rem    = 32'(da % db);
    assign hilo_out = op == MDU_MFHI ? hi : op == MDU_MFLO ? lo : 32'd0;
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            p_wr  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else if (state == S_IDLE) begin
            if (start && is_md(op)) begin
                state <= S_RUN;
                busy  <= 1'b1;
                cnt   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                p_hi  <= is_mul ? prod[63:32] : rem;
                p_lo  <= is_mul ? prod[31:0] : quot;
                p_wr  <= is_mul || b != 32'd0;
            end else if (!start && op == MDU_MTHI) begin
                hi <= a;
            end else if (!start && op == MDU_MTLO) begin
                lo <= a;
            end
        end else if (cnt == 4'd1) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (p_wr) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else begin
            cnt <= cnt - 4'd1;
        end
    end
endmodule
